// File: rtl/rgb_pkg.sv
// rtl/rgb_pkg.sv - shared mode type and bit-reverse helper for the rgb_dither video encoder
package rgb_pkg;

  typedef enum logic [1:0] {
    RGB_TRUNC  = 2'd0,
    RGB_BRIGHT = 2'd1,
    RGB_DITHER = 2'd2,
    RGB_RSVD   = 2'd3
  } rgb_mode_t;

  // Widest dither fraction the threshold helper handles.
  localparam int RGB_MAX_E = 16;

  // Reverse the low w bits of v; bits at and above w come back zero.
  function automatic logic [RGB_MAX_E-1:0] rgb_bitrev(input logic [RGB_MAX_E-1:0] v, input int w);
    logic [RGB_MAX_E-1:0] r;
    r = '0;
    for (int i = 0; i < RGB_MAX_E; i++) begin
      if (i < w) r[4'(i)] = v[4'(w - 1 - i)];
    end
    return r;
  endfunction

endpackage

// File: rtl/rgb_dither_ch.sv
// rtl/rgb_dither_ch.sv - one colour channel: truncate / bright-boost / ordered dither (combinational)
module rgb_dither_ch
  import rgb_pkg::*;
#(
  parameter  int IN_W  = 3,
  parameter  int OUT_W = 2,
  localparam int E     = IN_W - OUT_W,
  localparam int TW    = (E > 0) ? E : 1
) (
  input  logic [IN_W-1:0]  pix,
  input  logic [TW-1:0]    thr,
  input  rgb_mode_t        mode,
  output logic [OUT_W-1:0] val,
  output logic [OUT_W-1:0] oe
);

  logic [OUT_W-1:0] base;
  logic             bump;

  assign base = pix[IN_W-1:E];

  // A full-scale base must not roll over to zero when the fraction wins.
  if (E > 0) begin : g_frac
    assign bump = (pix[E-1:0] > thr) && !(&base);
  end else begin : g_nofrac
    assign bump = 1'b0;
  end

  always_comb begin
    val = base;
    oe  = '1;
    case (mode)
      RGB_BRIGHT: oe[0] = base[0];
      RGB_DITHER: val   = base + OUT_W'(bump);
      default:    ;
    endcase
  end

endmodule

// File: rtl/rgb_dither.sv
// rtl/rgb_dither.sv - CH-channel colour encoder onto OUT_W-bit DAC pins with per-frame mode and ordered dither
module rgb_dither
  import rgb_pkg::*;
#(
  parameter  int CH    = 3,
  parameter  int IN_W  = 3,
  parameter  int OUT_W = 2,
  localparam int E     = IN_W - OUT_W,
  localparam int PW    = (E > 0) ? E : 1
) (
  input  logic                  clk28,
  input  logic                  rst_n,
  input  logic                  pix_strobe,
  input  logic                  line_start,
  input  logic                  frame_start,
  input  logic [1:0]            mode,
  input  logic [CH*IN_W-1:0]    pix_i,
  output logic [CH*OUT_W-1:0]   pix_o,
  output logic [CH*OUT_W-1:0]   out_oe,
  output logic [PW-1:0]         phase_o
);

  if (IN_W < OUT_W || E > RGB_MAX_E) begin : g_bad_widths
    $error("rgb_dither: need OUT_W <= IN_W <= OUT_W + RGB_MAX_E");
  end

  rgb_mode_t          mode_q, mode_n;
  logic [PW-1:0]      phase_q, phase_n;
  logic [PW-1:0]      xpos_q, xpos_cur, xpos_nx;
  logic [PW-1:0]      thr;
  logic [CH*OUT_W-1:0] val_all, oe_all;
  logic               frame_hit;

  assign frame_hit = pix_strobe & frame_start;

  // The frame_start pixel itself already sees the newly latched mode and phase.
  assign mode_n = frame_hit ? rgb_mode_t'(mode) : mode_q;

  if (E > 0) begin : g_dither
    logic [PW-1:0] sum;
    assign phase_n  = frame_hit ? phase_q + PW'(1) : phase_q;
    assign xpos_cur = line_start ? '0 : xpos_q;
    assign xpos_nx  = xpos_cur + PW'(1);
    assign sum      = phase_n + xpos_cur;
    assign thr      = PW'(rgb_bitrev(RGB_MAX_E'(sum), PW));
  end else begin : g_no_dither
    assign phase_n  = '0;
    assign xpos_cur = '0;
    assign xpos_nx  = '0;
    assign thr      = '0;
  end

  for (genvar c = 0; c < CH; c++) begin : g_ch
    rgb_dither_ch #(
      .IN_W  (IN_W),
      .OUT_W (OUT_W)
    ) u_ch (
      .pix  (pix_i[c*IN_W +: IN_W]),
      .thr  (thr),
      .mode (mode_n),
      .val  (val_all[c*OUT_W +: OUT_W]),
      .oe   (oe_all[c*OUT_W +: OUT_W])
    );
  end

  always_ff @(posedge clk28) begin
    if (!rst_n) begin
      pix_o   <= '0;
      out_oe  <= '1;
      phase_q <= '0;
      mode_q  <= RGB_TRUNC;
      xpos_q  <= '0;
    end else if (pix_strobe) begin
      pix_o   <= val_all;
      out_oe  <= oe_all;
      phase_q <= phase_n;
      mode_q  <= mode_n;
      xpos_q  <= xpos_nx;
    end
  end

  assign phase_o = phase_q;

endmodule

// File: tb/tb_rgb_dither.sv
// tb/tb_rgb_dither.sv - scoreboard bench for rgb_dither at 3/3/2 and 3/4/2 widths
module tb_rgb_dither;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [5:0] pix;
    logic [5:0] oe;
    logic [1:0] ph;
  } exp_t;

  // Instance A: IN_W=3, OUT_W=2
  logic       rst_n_a, strobe_a, ls_a, fs_a;
  logic [1:0] mode_a;
  logic [8:0] pix_a;
  logic [5:0] pix_o_a, oe_a;
  logic [0:0] phase_a;

  // Instance B: IN_W=4, OUT_W=2
  logic        rst_n_b, strobe_b, ls_b, fs_b;
  logic [1:0]  mode_b;
  logic [11:0] pix_b;
  logic [5:0]  pix_o_b, oe_b;
  logic [1:0]  phase_b;

  rgb_dither #(.CH(3), .IN_W(3), .OUT_W(2)) dut_a (
    .clk28(clk), .rst_n(rst_n_a), .pix_strobe(strobe_a), .line_start(ls_a),
    .frame_start(fs_a), .mode(mode_a), .pix_i(pix_a),
    .pix_o(pix_o_a), .out_oe(oe_a), .phase_o(phase_a)
  );

  rgb_dither #(.CH(3), .IN_W(4), .OUT_W(2)) dut_b (
    .clk28(clk), .rst_n(rst_n_b), .pix_strobe(strobe_b), .line_start(ls_b),
    .frame_start(fs_b), .mode(mode_b), .pix_i(pix_b),
    .pix_o(pix_o_b), .out_oe(oe_b), .phase_o(phase_b)
  );

  exp_t qa[$];
  exp_t qb[$];
  exp_t last_a, last_b;
  logic fire_a, fire_b;
  int   checks = 0;
  int   errors = 0;

  localparam logic [8:0]  P011  = {3'b011, 3'b011, 3'b011};
  localparam logic [11:0] P0110 = 12'h666;

  task automatic chk(input string name, input logic [5:0] act, input logic [5:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp_v, $time);
    end
  endtask

  // Monitor A: a strobed or reset edge consumes one expectation; otherwise outputs must hold.
  initial forever begin
    @(posedge clk);
    fire_a = strobe_a | ~rst_n_a;
    #1;
    if (fire_a) begin
      if (qa.size() == 0) begin
        checks++; errors++;
        $display("FAIL a_queue: output update with no expected entry at %0t", $time);
      end else begin
        last_a = qa.pop_front();
        chk("a_pix", pix_o_a, last_a.pix);
        chk("a_oe", oe_a, last_a.oe);
        chk("a_phase", {5'd0, phase_a}, {4'd0, last_a.ph});
      end
    end else begin
      chk("a_hold_pix", pix_o_a, last_a.pix);
      chk("a_hold_oe", oe_a, last_a.oe);
    end
  end

  initial forever begin
    @(posedge clk);
    fire_b = strobe_b | ~rst_n_b;
    #1;
    if (fire_b) begin
      if (qb.size() == 0) begin
        checks++; errors++;
        $display("FAIL b_queue: output update with no expected entry at %0t", $time);
      end else begin
        last_b = qb.pop_front();
        chk("b_pix", pix_o_b, last_b.pix);
        chk("b_oe", oe_b, last_b.oe);
        chk("b_phase", {4'd0, phase_b}, {4'd0, last_b.ph});
      end
    end else begin
      chk("b_hold_pix", pix_o_b, last_b.pix);
      chk("b_hold_oe", oe_b, last_b.oe);
    end
  end

  task automatic step_a(input logic fs, input logic ls, input logic [1:0] m, input logic [8:0] p,
                        input logic [5:0] ep, input logic [5:0] eo, input logic [1:0] eph);
    strobe_a = 1'b1; fs_a = fs; ls_a = ls; mode_a = m; pix_a = p;
    qa.push_back('{pix: ep, oe: eo, ph: eph});
    @(negedge clk);
  endtask

  task automatic step_b(input logic fs, input logic ls, input logic [1:0] m, input logic [11:0] p,
                        input logic [5:0] ep, input logic [5:0] eo, input logic [1:0] eph);
    strobe_b = 1'b1; fs_b = fs; ls_b = ls; mode_b = m; pix_b = p;
    qb.push_back('{pix: ep, oe: eo, ph: eph});
    @(negedge clk);
  endtask

  task automatic idle_a(input int n, input logic fs);
    strobe_a = 1'b0; fs_a = fs; ls_a = 1'b0;
    repeat (n) @(negedge clk);
    fs_a = 1'b0;
  endtask

  initial begin
    // Reset held with strobe high and all-ones input on both instances.
    rst_n_a = 1'b0; strobe_a = 1'b1; ls_a = 1'b0; fs_a = 1'b1; mode_a = 2'd2; pix_a = '1;
    rst_n_b = 1'b0; strobe_b = 1'b1; ls_b = 1'b0; fs_b = 1'b1; mode_b = 2'd2; pix_b = '1;
    repeat (3) begin
      qa.push_back('{pix: 6'h00, oe: 6'h3F, ph: 2'd0});
      qb.push_back('{pix: 6'h00, oe: 6'h3F, ph: 2'd0});
    end
    repeat (3) @(negedge clk);
    rst_n_a = 1'b1; rst_n_b = 1'b1;
    strobe_b = 1'b0; fs_b = 1'b0;

    // Truncate G=7 R=4 B=3, then hold for 5 clocks.
    step_a(1, 1, 2'd0, {3'd7, 3'd4, 3'd3}, 6'h39, 6'h3F, 2'd1);
    idle_a(5, 1'b0);

    // Bright-boost: zero LSBs are tristated.
    step_a(1, 1, 2'd1, {3'd2, 3'd6, 3'd0}, 6'h1C, 6'h3E, 2'd0);
    step_a(0, 0, 2'd1, {3'd1, 3'd3, 3'd5}, 6'h06, 6'h2E, 2'd0);

    // Filler frame brings the phase back round to 0 for the dither frame.
    step_a(1, 1, 2'd0, 9'd0, 6'h00, 6'h3F, 2'd1);

    // Dither, phase 0: 10,01,10,01.
    step_a(1, 1, 2'd2, P011, 6'h2A, 6'h3F, 2'd0);
    step_a(0, 0, 2'd2, P011, 6'h15, 6'h3F, 2'd0);
    step_a(0, 0, 2'd2, P011, 6'h2A, 6'h3F, 2'd0);
    step_a(0, 0, 2'd2, P011, 6'h15, 6'h3F, 2'd0);

    // Dither, phase 1: 01,10,01,10; then saturation and a zero fraction.
    step_a(1, 1, 2'd2, P011, 6'h15, 6'h3F, 2'd1);
    step_a(0, 0, 2'd2, P011, 6'h2A, 6'h3F, 2'd1);
    step_a(0, 0, 2'd2, P011, 6'h15, 6'h3F, 2'd1);
    step_a(0, 0, 2'd2, P011, 6'h2A, 6'h3F, 2'd1);
    step_a(0, 1, 2'd2, 9'h1FF, 6'h3F, 6'h3F, 2'd1);
    step_a(0, 0, 2'd2, 9'h1FF, 6'h3F, 6'h3F, 2'd1);
    step_a(0, 0, 2'd2, {3'b010, 3'b010, 3'b010}, 6'h15, 6'h3F, 2'd1);

    // Mode change mid-frame stays truncated; frame_start without strobe is ignored.
    step_a(1, 1, 2'd0, P011, 6'h15, 6'h3F, 2'd0);
    step_a(0, 0, 2'd2, P011, 6'h15, 6'h3F, 2'd0);
    step_a(0, 0, 2'd2, P011, 6'h15, 6'h3F, 2'd0);
    idle_a(1, 1'b1);
    // xpos=3 with new phase 1 gives thr 0; the old phase would give thr 1.
    step_a(1, 0, 2'd2, P011, 6'h2A, 6'h3F, 2'd1);
    // Reserved mode behaves as truncate.
    step_a(1, 1, 2'd3, {3'd7, 3'd4, 3'd3}, 6'h39, 6'h3F, 2'd0);
    idle_a(2, 1'b0);

    // E=2: 0110 at xpos 0 over phases 1,2,3,0 -> thr 2,1,3,0.
    step_b(1, 1, 2'd2, P0110, 6'h15, 6'h3F, 2'd1);
    step_b(1, 1, 2'd2, P0110, 6'h2A, 6'h3F, 2'd2);
    step_b(1, 1, 2'd2, P0110, 6'h15, 6'h3F, 2'd3);
    step_b(1, 1, 2'd2, P0110, 6'h2A, 6'h3F, 2'd0);
    step_b(0, 0, 2'd2, P0110, 6'h15, 6'h3F, 2'd0);
    step_b(0, 0, 2'd2, P0110, 6'h2A, 6'h3F, 2'd0);
    step_b(0, 0, 2'd2, P0110, 6'h15, 6'h3F, 2'd0);

    // Reset mid-line, then truncate until the next frame_start.
    rst_n_b = 1'b0;
    step_b(0, 0, 2'd2, 12'hFFF, 6'h00, 6'h3F, 2'd0);
    rst_n_b = 1'b1;
    step_b(0, 0, 2'd2, P0110, 6'h15, 6'h3F, 2'd0);
    step_b(1, 1, 2'd2, 12'hFFF, 6'h3F, 6'h3F, 2'd1);
    step_b(0, 0, 2'd2, P0110, 6'h2A, 6'h3F, 2'd1);
    strobe_b = 1'b0; fs_b = 1'b0; ls_b = 1'b0;
    repeat (3) @(negedge clk);

    checks++;
    if (qa.size() != 0 || qb.size() != 0) begin
      errors++;
      $display("FAIL queues_drained: got %0d/%0d entries left expected 0/0", qa.size(), qb.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
